// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: operand-select and FSM
// encodings plus the per-stage destination record.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    DEP_REG  = 2'b00,
    DEP_IMM  = 2'b01,
    DEP_MALU = 2'b10,
    DEP_WDI  = 2'b11
  } depen_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_LSTALL = 2'b01,
    ST_FLUSH  = 2'b10,
    ST_DSTALL = 2'b11
  } state_e;

  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic [4:0] rn;
  } dest_rec_t;

  localparam dest_rec_t REC_NONE = '0;

  // Nearest producer wins: EX result (malu) before MEM result (wdi).
  function automatic depen_e sel_depen(input logic imm, input logic ex_hit,
                                       input logic mem_hit);
    if (imm)          return DEP_IMM;
    else if (ex_hit)  return DEP_MALU;
    else if (mem_hit) return DEP_WDI;
    else              return DEP_REG;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage decode fields in, operand selects and pipeline control out.
interface pipe_hazard_ctrl_if;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic       d_use_rs;
  logic       d_use_rt;
  logic       d_shift;
  logic       d_aluimm;
  logic       d_wreg;
  logic       d_m2reg;
  logic [4:0] d_rn;
  logic       ex_is_uncond;
  logic       ex_is_cond;
  logic [1:0] e_adepen;
  logic [1:0] e_bdepen;
  logic       stall;
  logic       bubble;
  logic       flush;
  logic [1:0] state;

  modport master (
    output d_rs, d_rt, d_use_rs, d_use_rt, d_shift, d_aluimm,
           d_wreg, d_m2reg, d_rn, ex_is_uncond, ex_is_cond,
    input  e_adepen, e_bdepen, stall, bubble, flush, state
  );

  modport slave (
    input  d_rs, d_rt, d_use_rs, d_use_rt, d_shift, d_aluimm,
           d_wreg, d_m2reg, d_rn, ex_is_uncond, ex_is_cond,
    output e_adepen, e_bdepen, stall, bubble, flush, state
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Compares one ID source register against one downstream destination record.
module hazard_cmp
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic       use_i,
  input  dest_rec_t  rec_i,
  output logic       hit_o
);
  // r0 is hardwired zero, so a write to it never creates a dependence.
  assign hit_o = rec_i.wreg && use_i && (rec_i.rn == src_i) && (rec_i.rn != 5'd0);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection, forwarding select and stall/flush control for a 5-stage pipe.
// Define PIPE_HAZARD_FWD_EN for forwarding; otherwise EX/MEM dependences stall.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  pipe_hazard_ctrl_if.slave  hz_if
);

  dest_rec_t ex_rec_q, mem_rec_q, wb_rec_q, ex_rec_d;
  state_e    state_q, state_d;
  depen_e    adep_q, bdep_q, adep_d, bdep_d;

  logic ex_a, ex_b, mem_a, mem_b, wb_a, wb_b;
  logic jump, data_haz, stall, flush, bubble;
  state_e haz_state;

  hazard_cmp u_cmp_ex_a  (.src_i(hz_if.d_rs), .use_i(hz_if.d_use_rs), .rec_i(ex_rec_q),  .hit_o(ex_a));
  hazard_cmp u_cmp_ex_b  (.src_i(hz_if.d_rt), .use_i(hz_if.d_use_rt), .rec_i(ex_rec_q),  .hit_o(ex_b));
  hazard_cmp u_cmp_mem_a (.src_i(hz_if.d_rs), .use_i(hz_if.d_use_rs), .rec_i(mem_rec_q), .hit_o(mem_a));
  hazard_cmp u_cmp_mem_b (.src_i(hz_if.d_rt), .use_i(hz_if.d_use_rt), .rec_i(mem_rec_q), .hit_o(mem_b));
  hazard_cmp u_cmp_wb_a  (.src_i(hz_if.d_rs), .use_i(hz_if.d_use_rs), .rec_i(wb_rec_q),  .hit_o(wb_a));
  hazard_cmp u_cmp_wb_b  (.src_i(hz_if.d_rt), .use_i(hz_if.d_use_rt), .rec_i(wb_rec_q),  .hit_o(wb_b));

  // WB hits never stall: the register file writes in the first half-cycle.
  logic unused_bits;
  assign unused_bits = ^{wb_a, wb_b, mem_rec_q.m2reg, wb_rec_q.m2reg, ex_rec_q.m2reg};

  always_comb begin
    jump = hz_if.ex_is_uncond | hz_if.ex_is_cond;
`ifdef PIPE_HAZARD_FWD_EN
    data_haz  = ex_rec_q.m2reg & (ex_a | ex_b);
    haz_state = ST_LSTALL;
`else
    data_haz  = ex_a | ex_b | mem_a | mem_b;
    haz_state = ST_DSTALL;
`endif
    flush  = !rst_i && jump;
    stall  = !rst_i && data_haz && !jump;
    bubble = flush | stall;

    state_d = ST_RUN;
    if (jump)          state_d = ST_FLUSH;
    else if (data_haz) state_d = haz_state;

    adep_d = DEP_REG;
    bdep_d = DEP_REG;
    if (!bubble) begin
`ifdef PIPE_HAZARD_FWD_EN
      adep_d = sel_depen(hz_if.d_shift,  ex_a, mem_a);
      bdep_d = sel_depen(hz_if.d_aluimm, ex_b, mem_b);
`else
      adep_d = hz_if.d_shift  ? DEP_IMM : DEP_REG;
      bdep_d = hz_if.d_aluimm ? DEP_IMM : DEP_REG;
`endif
    end

    ex_rec_d = REC_NONE;
    if (!bubble) begin
      ex_rec_d.wreg  = hz_if.d_wreg;
      ex_rec_d.m2reg = hz_if.d_m2reg;
      ex_rec_d.rn    = hz_if.d_rn;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_RUN;
      adep_q    <= DEP_REG;
      bdep_q    <= DEP_REG;
      ex_rec_q  <= REC_NONE;
      mem_rec_q <= REC_NONE;
      wb_rec_q  <= REC_NONE;
    end else begin
      state_q   <= state_d;
      adep_q    <= adep_d;
      bdep_q    <= bdep_d;
      ex_rec_q  <= ex_rec_d;
      mem_rec_q <= ex_rec_q;
      wb_rec_q  <= mem_rec_q;
    end
  end

  assign hz_if.stall    = stall;
  assign hz_if.bubble   = bubble;
  assign hz_if.flush    = flush;
  assign hz_if.state    = state_q;
  assign hz_if.e_adepen = adep_q;
  assign hz_if.e_bdepen = bdep_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; expectations follow PIPE_HAZARD_FWD_EN.
module tb_pipe_hazard_ctrl;

  logic clk;
  logic rst;
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  pipe_hazard_ctrl_if hz();

  pipe_hazard_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .hz_if (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.d_rs = '0; hz.d_rt = '0; hz.d_use_rs = 1'b0; hz.d_use_rt = 1'b0;
    hz.d_shift = 1'b0; hz.d_aluimm = 1'b0; hz.d_wreg = 1'b0; hz.d_m2reg = 1'b0;
    hz.d_rn = '0; hz.ex_is_uncond = 1'b0; hz.ex_is_cond = 1'b0;
  endtask

  task automatic id(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                    input logic urt, input logic wreg, input logic m2reg,
                    input logic [4:0] rn);
    hz.d_rs = rs; hz.d_rt = rt; hz.d_use_rs = urs; hz.d_use_rt = urt;
    hz.d_shift = 1'b0; hz.d_aluimm = 1'b0;
    hz.d_wreg = wreg; hz.d_m2reg = m2reg; hz.d_rn = rn;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    hz.ex_is_cond = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state",  {2'b0, hz.state},    4'h0);
    check("rst_adepen", {2'b0, hz.e_adepen}, 4'h0);
    check("rst_bdepen", {2'b0, hz.e_bdepen}, 4'h0);
    check("rst_stall",  {3'b0, hz.stall},    4'h0);
    check("rst_bubble", {3'b0, hz.bubble},   4'h0);
    check("rst_flush",  {3'b0, hz.flush},    4'h0);
    hz.ex_is_cond = 1'b0;
    rst = 1'b0;
    tick();

    // r0 writes never create a dependence
    id(5'd1, 5'd2, 1, 1, 1, 0, 5'd0); tick();
    id(5'd0, 5'd0, 1, 1, 1, 0, 5'd5); #2;
    check("r0_stall", {3'b0, hz.stall}, 4'h0);
    tick();
    check("r0_adepen", {2'b0, hz.e_adepen}, 4'h0);
    check("r0_bdepen", {2'b0, hz.e_bdepen}, 4'h0);
    drain();

    // add r3,r1,r2 ; sub r4,r3,r5
    id(5'd1, 5'd2, 1, 1, 1, 0, 5'd3); tick();
    id(5'd3, 5'd5, 1, 1, 1, 0, 5'd4); #2;
`ifdef PIPE_HAZARD_FWD_EN
    check("exfwd_stall", {3'b0, hz.stall}, 4'h0);
    tick();
    check("exfwd_adepen", {2'b0, hz.e_adepen}, 4'h2);
    check("exfwd_bdepen", {2'b0, hz.e_bdepen}, 4'h0);
`else
    check("dst_stall1",  {3'b0, hz.stall},  4'h1);
    check("dst_bubble1", {3'b0, hz.bubble}, 4'h1);
    tick();
    check("dst_state1",  {2'b0, hz.state},    4'h3);
    check("dst_adepen1", {2'b0, hz.e_adepen}, 4'h0);
    #2;
    check("dst_stall2", {3'b0, hz.stall}, 4'h1);
    tick();
    check("dst_state2", {2'b0, hz.state}, 4'h3);
    #2;
    check("dst_stall3", {3'b0, hz.stall}, 4'h0);
    tick();
    check("dst_state3",  {2'b0, hz.state},    4'h0);
    check("dst_adepen3", {2'b0, hz.e_adepen}, 4'h0);
`endif
    drain();

    // add r3 ; nop ; or r6,r0,r3
    id(5'd1, 5'd2, 1, 1, 1, 0, 5'd3); tick();
    idle(); tick();
    id(5'd0, 5'd3, 1, 1, 1, 0, 5'd6); #2;
`ifdef PIPE_HAZARD_FWD_EN
    check("memfwd_stall", {3'b0, hz.stall}, 4'h0);
    tick();
    check("memfwd_bdepen", {2'b0, hz.e_bdepen}, 4'h3);
    check("memfwd_adepen", {2'b0, hz.e_adepen}, 4'h0);
`else
    check("dmem_stall1", {3'b0, hz.stall}, 4'h1);
    tick();
    check("dmem_state1", {2'b0, hz.state}, 4'h3);
    #2;
    check("dmem_stall2", {3'b0, hz.stall}, 4'h0);
    tick();
    check("dmem_bdepen", {2'b0, hz.e_bdepen}, 4'h0);
    check("dmem_state2", {2'b0, hz.state},    4'h0);
`endif
    drain();

    // lw r2,0(r1) ; add r4,r2,r2
    id(5'd1, 5'd0, 1, 0, 1, 1, 5'd2); tick();
    id(5'd2, 5'd2, 1, 1, 1, 0, 5'd4); #2;
    check("lu_stall",  {3'b0, hz.stall},  4'h1);
    check("lu_bubble", {3'b0, hz.bubble}, 4'h1);
    check("lu_flush",  {3'b0, hz.flush},  4'h0);
    tick();
`ifdef PIPE_HAZARD_FWD_EN
    check("lu_state", {2'b0, hz.state}, 4'h1);
    #2;
    check("lu_stall_end", {3'b0, hz.stall}, 4'h0);
    tick();
    check("lu_adepen", {2'b0, hz.e_adepen}, 4'h3);
    check("lu_bdepen", {2'b0, hz.e_bdepen}, 4'h3);
`else
    check("lu_state", {2'b0, hz.state}, 4'h3);
    #2;
    check("lu_stall2", {3'b0, hz.stall}, 4'h1);
    tick();
    #2;
    check("lu_stall_end", {3'b0, hz.stall}, 4'h0);
    tick();
    check("lu_adepen", {2'b0, hz.e_adepen}, 4'h0);
`endif
    check("lu_state_run", {2'b0, hz.state}, 4'h0);
    drain();

    // taken branch in EX coincident with load-use: flush wins
    id(5'd1, 5'd0, 1, 0, 1, 1, 5'd2); tick();
    id(5'd2, 5'd2, 1, 1, 1, 0, 5'd4);
    hz.ex_is_cond = 1'b1; #2;
    check("br_flush",  {3'b0, hz.flush},  4'h1);
    check("br_bubble", {3'b0, hz.bubble}, 4'h1);
    check("br_stall",  {3'b0, hz.stall},  4'h0);
    tick();
    check("br_state", {2'b0, hz.state}, 4'h2);
    idle(); #2;
    check("br_flush_end", {3'b0, hz.flush}, 4'h0);
    tick();
    check("br_state_run", {2'b0, hz.state}, 4'h0);
    drain();

    // shift/immediate selects override forwarding
`ifdef PIPE_HAZARD_FWD_EN
    id(5'd1, 5'd2, 1, 1, 1, 0, 5'd3); tick();
    id(5'd3, 5'd3, 1, 1, 1, 0, 5'd7);
    hz.d_shift = 1'b1; tick();
    check("shift_adepen", {2'b0, hz.e_adepen}, 4'h1);
    check("shift_bdepen", {2'b0, hz.e_bdepen}, 4'h2);
`else
    id(5'd3, 5'd4, 1, 1, 1, 0, 5'd7);
    hz.d_shift = 1'b1; hz.d_aluimm = 1'b1; tick();
    check("shift_adepen", {2'b0, hz.e_adepen}, 4'h1);
    check("shift_bdepen", {2'b0, hz.e_bdepen}, 4'h1);
`endif
    drain();

    // producer already in WB: no stall, read the register file
    id(5'd1, 5'd2, 1, 1, 1, 0, 5'd3); tick();
    idle(); tick(); tick();
    id(5'd3, 5'd3, 1, 1, 1, 0, 5'd8); #2;
    check("wb_stall", {3'b0, hz.stall}, 4'h0);
    tick();
    check("wb_adepen", {2'b0, hz.e_adepen}, 4'h0);
    check("wb_bdepen", {2'b0, hz.e_bdepen}, 4'h0);
    drain();

    // reset asserted mid-stall abandons it
    id(5'd1, 5'd0, 1, 0, 1, 1, 5'd2); tick();
    id(5'd2, 5'd2, 1, 1, 1, 0, 5'd4); #2;
    check("rms_stall_pre", {3'b0, hz.stall}, 4'h1);
    tick();
`ifdef PIPE_HAZARD_FWD_EN
    check("rms_state_pre", {2'b0, hz.state}, 4'h1);
`else
    check("rms_state_pre", {2'b0, hz.state}, 4'h3);
`endif
    #2;
    rst = 1'b1; #1;
    check("rms_state",  {2'b0, hz.state},    4'h0);
    check("rms_stall",  {3'b0, hz.stall},    4'h0);
    check("rms_bubble", {3'b0, hz.bubble},   4'h0);
    check("rms_adepen", {2'b0, hz.e_adepen}, 4'h0);
    rst = 1'b0; #1;
    check("rms_no_residual", {3'b0, hz.bubble}, 4'h0);
    tick();
    check("rms_state_post", {2'b0, hz.state}, 4'h0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 clock  input  1  pipeline clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 d_rs, d_rt  input  5 each  source register numbers of the ID-stage instruction.
REQ-004 d_use_rs, d_use_rt  input  1 each  ID instruction reads rs / rt.
REQ-005 d_shift, d_aluimm  input  1 each  ALU A takes shift amount / ALU B takes immediate.
REQ-006 d_wreg, d_m2reg  input  1 each  ID instruction writes a register / is a load.
REQ-007 d_rn  input  5  ID destination register number, after jal remap to 31.
REQ-008 ex_is_uncond, ex_is_cond  input  1 each  EX-stage jump / taken-branch indication.
REQ-009 e_adepen, e_bdepen  output  2 each  registered ALU A/B operand select: 00 register, 01 shift-amount/immediate, 10 malu, 11 wdi.
REQ-010 stall  output  1  freeze PC and IF/ID register.
REQ-011 bubble  output  1  load NOP into ID/EX (clear ewreg, ewmem).
REQ-012 flush  output  1  kill IF/ID contents.
REQ-013 state  output  2  FSM state for debug: 00 RUN, 01 LSTALL, 10 FLUSH, 11 DSTALL.

Function
REQ-014 Block SHALL keep shadow destination records {wreg, m2reg, rn} for EX, MEM and WB stages, shifted one stage per cycle.
REQ-015 A bubble or flush SHALL enter the EX record with wreg=0.
REQ-016 A source SHALL match a record only if that record has wreg=1, its rn equals the source, the source is used, and rn is nonzero.
REQ-017 e_adepen SHALL be 01 when d_shift=1, regardless of hazards.
REQ-018 Otherwise, e_adepen SHALL be 10 on an EX-record match, else 11 on a MEM-record match, else 00; nearest producer wins.
REQ-019 e_bdepen SHALL follow the same rule as e_adepen, using d_aluimm and d_rt.
REQ-020 e_adepen and e_bdepen SHALL be registered on the edge that moves ID into EX, giving zero added latency relative to ea/eb.
REQ-021 Load-use hazard: EX record has m2reg=1 and matches a used source. SHALL assert stall and bubble for exactly 1 cycle and enter LSTALL, then return to RUN.
REQ-022 On ex_is_uncond or ex_is_cond, SHALL assert flush and bubble for 1 cycle and enter FLUSH, then return to RUN.
REQ-023 Branch/jump in the same cycle as a load-use hazard: flush wins and stall is not asserted.
REQ-024 During stall, the MEM and WB records SHALL still advance, and e_*depen SHALL be 00.
REQ-025 stall, bubble and flush SHALL be combinational from the current state and inputs; state and e_*depen SHALL be registered.

Reset
REQ-026 Reset asserted SHALL immediately force all records wreg=0, state=RUN, and e_adepen=e_bdepen=00.
REQ-027 stall, bubble and flush SHALL be 0 while reset is high.
REQ-028 Reset mid-stall SHALL abandon the stall with no residual bubble.

Configuration
REQ-029 Macro PIPE_HAZARD_FWD_EN defined: forwarding per REQ-017 to REQ-021.
REQ-030 PIPE_HAZARD_FWD_EN undefined: e_*depen SHALL only take 00 or 01.
REQ-031 PIPE_HAZARD_FWD_EN undefined: any EX or MEM match SHALL stall with bubble in state DSTALL until no match remains (at most 2 cycles).
REQ-032 In both configurations, a WB match SHALL not stall, because the register file writes before it is read.

Structure
REQ-033 Shared package SHALL hold the depen encodings (DEP_REG, DEP_IMM, DEP_MALU, DEP_WDI) and the state encodings.
REQ-034 One sub-module, hazard_cmp, SHALL compare one source against one record; it is instantiated per source per stage.

Verification
REQ-035 add r3,r1,r2 then sub r4,r3,r5 -> e_adepen=10 for sub, no stall.
REQ-036 add r3,.. ; nop ; or r6,r0,r3 -> e_bdepen=11 for or.
REQ-037 lw r2,0(r1) then add r4,r2,r2 -> stall=bubble=1 for exactly 1 cycle, then e_adepen=e_bdepen=11.
REQ-038 beq taken (ex_is_cond=1) coincident with a load-use hazard -> flush=bubble=1, stall=0, state 10 then 00.
REQ-039 Writes to r0 followed by a read of r0 -> e_adepen=00 and no stall, in both configurations.
REQ-040 Macro off, add r3 then sub r4,r3,r5 -> 2 stall cycles in DSTALL, e_adepen=00; reset mid-stall clears all outputs to 0.
